// File: rtl/imm_extender_pipe_pkg.sv
// Shared types for the immediate extender: format select encoding and the
// output skid-buffer state.
package imm_extender_pipe_pkg;

    typedef enum logic [2:0] {
        IMM_I    = 3'b000,
        IMM_S    = 3'b001,
        IMM_B    = 3'b010,
        IMM_U    = 3'b011,
        IMM_J    = 3'b100,
        IMM_Z    = 3'b101,
        IMM_SH   = 3'b110,
        IMM_RSVD = 3'b111
    } imm_sel_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/imm_format_xlen.sv
// Combinational immediate extraction and extension from instr[31:7] to XLEN
// bits; the reserved select yields the I-type result with IMM_ERR raised.
module imm_format_xlen #(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      IMM_SEL,
    input  logic [24:0]     IR,
    output logic [XLEN-1:0] IMM,
    output logic            IMM_ERR
);
    import imm_extender_pipe_pkg::*;

    // Indexed by instruction bit position so the field slices read like the ISA manual.
    logic [31:7]     w_instr;
    logic [XLEN-1:0] w_sign;

    assign w_instr = IR;
    assign w_sign  = {XLEN{w_instr[31]}};

    always_comb begin
        IMM     = '0;
        IMM_ERR = 1'b0;
        case (imm_sel_e'(IMM_SEL))
            IMM_I: begin
                IMM       = w_sign;
                IMM[11:0] = w_instr[31:20];
            end
            IMM_S: begin
                IMM       = w_sign;
                IMM[11:0] = {w_instr[31:25], w_instr[11:7]};
            end
            IMM_B: begin
                IMM       = w_sign;
                IMM[12:0] = {w_instr[31], w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
            end
            IMM_U: begin
                IMM       = w_sign;
                IMM[31:0] = {w_instr[31:12], 12'b0};
            end
            IMM_J: begin
                IMM       = w_sign;
                IMM[20:0] = {w_instr[31], w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};
            end
            IMM_Z: begin
                IMM[4:0] = w_instr[19:15];
            end
            IMM_SH: begin
                if (XLEN == 64) IMM[5:0] = w_instr[25:20];
                else            IMM[4:0] = w_instr[24:20];
            end
            IMM_RSVD: begin
                IMM       = w_sign;
                IMM[11:0] = w_instr[31:20];
                IMM_ERR   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/imm_extender_pipe.sv
// One-cycle pipelined immediate extender with valid/ready on both sides and a
// 2-entry (main + skid) output buffer; IN_READY is registered from state only.
module imm_extender_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [2:0]       IMM_SEL,
    input  logic [24:0]      IR,
    input  logic [TAG_W-1:0] IN_TAG,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [XLEN-1:0]  IMM,
    output logic [TAG_W-1:0] OUT_TAG,
    output logic             IMM_ERR
);
    import imm_extender_pipe_pkg::*;

    skid_state_e      r_state;
    skid_state_e      w_next_state;
    logic             r_in_ready;
    logic [XLEN-1:0]  r_main_imm;
    logic [TAG_W-1:0] r_main_tag;
    logic             r_main_err;
    logic [XLEN-1:0]  r_skid_imm;
    logic [TAG_W-1:0] r_skid_tag;
    logic             r_skid_err;

    logic [XLEN-1:0]  w_imm;
    logic             w_err;
    logic             w_accept;
    logic             w_drain;
    logic             w_load_main;
    logic             w_load_skid;
    logic             w_promote;

    imm_format_xlen #(.XLEN(XLEN)) u_format (
        .IMM_SEL (IMM_SEL),
        .IR      (IR),
        .IMM     (w_imm),
        .IMM_ERR (w_err)
    );

    assign w_accept  = IN_VALID && r_in_ready;
    assign w_drain   = (r_state != ST_EMPTY) && OUT_READY;
    assign IN_READY  = r_in_ready;
    assign OUT_VALID = (r_state != ST_EMPTY);
    assign IMM       = r_main_imm;
    assign OUT_TAG   = r_main_tag;
    assign IMM_ERR   = r_main_err;

    always_comb begin
        w_next_state = r_state;
        w_load_main  = 1'b0;
        w_load_skid  = 1'b0;
        w_promote    = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_next_state = ST_FULL;
                    w_load_main  = 1'b1;
                end
            end
            ST_FULL: begin
                if (w_accept && w_drain) begin
                    w_load_main = 1'b1;
                end else if (w_accept) begin
                    w_next_state = ST_SKID;
                    w_load_skid  = 1'b1;
                end else if (w_drain) begin
                    w_next_state = ST_EMPTY;
                end
            end
            // IN_READY is low here, so no accept can coincide with the promote.
            ST_SKID: begin
                if (w_drain) begin
                    w_next_state = ST_FULL;
                    w_promote    = 1'b1;
                end
            end
            default: w_next_state = ST_EMPTY;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b0;
            r_main_imm <= '0;
            r_main_tag <= '0;
            r_main_err <= 1'b0;
            r_skid_imm <= '0;
            r_skid_tag <= '0;
            r_skid_err <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= (w_next_state != ST_SKID);
            if (w_load_main) begin
                r_main_imm <= w_imm;
                r_main_tag <= IN_TAG;
                r_main_err <= w_err;
            end else if (w_promote) begin
                r_main_imm <= r_skid_imm;
                r_main_tag <= r_skid_tag;
                r_main_err <= r_skid_err;
            end
            if (w_load_skid) begin
                r_skid_imm <= w_imm;
                r_skid_tag <= IN_TAG;
                r_skid_err <= w_err;
            end
        end
    end

endmodule

// File: tb/tb_imm_extender_pipe.sv
// Directed and randomised checks of imm_extender_pipe at XLEN=32 and XLEN=64
// driven from shared stimulus.
module tb_imm_extender_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [2:0]  imm_sel;
    logic [24:0] ir;
    logic [3:0]  in_tag;
    logic        out_ready;

    logic        rdy32, ov32, err32;
    logic [31:0] imm32;
    logic [3:0]  tag32;
    logic        rdy64, ov64, err64;
    logic [63:0] imm64;
    logic [3:0]  tag64;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    imm_extender_pipe #(.XLEN(32), .TAG_W(4)) u32 (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(rdy32),
        .IMM_SEL(imm_sel), .IR(ir), .IN_TAG(in_tag), .OUT_VALID(ov32),
        .OUT_READY(out_ready), .IMM(imm32), .OUT_TAG(tag32), .IMM_ERR(err32)
    );

    imm_extender_pipe #(.XLEN(64), .TAG_W(4)) u64 (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(rdy64),
        .IMM_SEL(imm_sel), .IR(ir), .IN_TAG(in_tag), .OUT_VALID(ov64),
        .OUT_READY(out_ready), .IMM(imm64), .OUT_TAG(tag64), .IMM_ERR(err64)
    );

    function automatic logic [31:0] ref_imm32(input logic [2:0] sel, input logic [31:0] ins);
        case (sel)
            3'd1:    ref_imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            3'd2:    ref_imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            3'd3:    ref_imm32 = {ins[31:12], 12'b0};
            3'd4:    ref_imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            3'd5:    ref_imm32 = {27'b0, ins[19:15]};
            3'd6:    ref_imm32 = {27'b0, ins[24:20]};
            default: ref_imm32 = {{20{ins[31]}}, ins[31:20]};
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        imm_sel = 3'd0; ir = '0; in_tag = '0;
        repeat (2) tick();
        total++; if (ov32 !== 1'b0)  begin bad++; $display("FAIL reset_ovalid got=%b want=0", ov32); end
        total++; if (imm32 !== '0)   begin bad++; $display("FAIL reset_imm got=%h want=0", imm32); end
        total++; if (tag32 !== '0)   begin bad++; $display("FAIL reset_tag got=%h want=0", tag32); end
        total++; if (err32 !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err32); end
        total++; if (rdy32 !== 1'b0) begin bad++; $display("FAIL reset_inready got=%b want=0", rdy32); end
        rst = 1'b0;
        tick();
        total++; if (rdy32 !== 1'b1) begin bad++; $display("FAIL post_reset_inready got=%b want=1", rdy32); end
        total++; if (rdy64 !== 1'b1) begin bad++; $display("FAIL post_reset_inready64 got=%b want=1", rdy64); end
    endtask

    task automatic test_formats();
        logic [31:0] ins = 32'hDEADBEEF;
        logic [31:0] exp32 [8] = '{32'hFFFFFDEA, 32'hFFFFFDFD, 32'hFFFFFDFC, 32'hDEADB000,
                                   32'hFFFDB5EA, 32'h0000001B, 32'h0000000A, 32'hFFFFFDEA};
        ir = ins[31:7];
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            imm_sel  = 3'(k);
            in_tag   = 4'(k + 1);
            tick();
            total++; if (ov32 !== 1'b1) begin bad++; $display("FAIL fmt%0d_ovalid got=%b want=1", k, ov32); end
            total++; if (imm32 !== exp32[k]) begin bad++; $display("FAIL fmt%0d_imm got=%h want=%h", k, imm32, exp32[k]); end
            total++; if (err32 !== (k == 7)) begin bad++; $display("FAIL fmt%0d_err got=%b want=%b", k, err32, (k == 7)); end
            total++; if (tag32 !== 4'(k + 1)) begin bad++; $display("FAIL fmt%0d_tag got=%h want=%h", k, tag32, 4'(k + 1)); end
            total++; if (rdy32 !== 1'b1) begin bad++; $display("FAIL fmt%0d_inready got=%b want=1", k, rdy32); end
            if (k == 0) begin
                total++; if (imm64 !== 64'hFFFFFFFFFFFFFDEA) begin bad++; $display("FAIL x64_I got=%h want=FFFFFFFFFFFFFDEA", imm64); end
            end
            if (k == 3) begin
                total++; if (imm64 !== 64'hFFFFFFFFDEADB000) begin bad++; $display("FAIL x64_U got=%h want=FFFFFFFFDEADB000", imm64); end
            end
            if (k == 6) begin
                total++; if (imm64 !== 64'h000000000000002A) begin bad++; $display("FAIL x64_SH got=%h want=000000000000002A", imm64); end
            end
            if (k == 7) begin
                total++; if (err64 !== 1'b1) begin bad++; $display("FAIL x64_err got=%b want=1", err64); end
            end
        end
        in_valid = 1'b0;
        tick();
        total++; if (ov32 !== 1'b0) begin bad++; $display("FAIL fmt_drain_ovalid got=%b want=0", ov32); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins = 32'h12345693;
        ir = ins[31:7];
        imm_sel = 3'd0;
        out_ready = 1'b0;
        in_valid = 1'b1; in_tag = 4'd1;
        tick();
        total++; if (tag32 !== 4'd1 || ov32 !== 1'b1) begin bad++; $display("FAIL bp_first got=%h/%b want=1/1", tag32, ov32); end
        total++; if (rdy32 !== 1'b1) begin bad++; $display("FAIL bp_ready1 got=%b want=1", rdy32); end
        in_tag = 4'd2;
        tick();
        total++; if (rdy32 !== 1'b0) begin bad++; $display("FAIL bp_ready_skid got=%b want=0", rdy32); end
        total++; if (tag32 !== 4'd1) begin bad++; $display("FAIL bp_hold1 got=%h want=1", tag32); end
        in_tag = 4'd3;
        tick();
        total++; if (rdy32 !== 1'b0) begin bad++; $display("FAIL bp_ready_held got=%b want=0", rdy32); end
        total++; if (tag32 !== 4'd1) begin bad++; $display("FAIL bp_hold1b got=%h want=1", tag32); end
        out_ready = 1'b1;
        tick();
        total++; if (tag32 !== 4'd2 || ov32 !== 1'b1) begin bad++; $display("FAIL bp_second got=%h/%b want=2/1", tag32, ov32); end
        total++; if (imm32 !== 32'h00000123) begin bad++; $display("FAIL bp_imm got=%h want=00000123", imm32); end
        tick();
        in_valid = 1'b0;
        total++; if (tag32 !== 4'd3 || ov32 !== 1'b1) begin bad++; $display("FAIL bp_third got=%h/%b want=3/1", tag32, ov32); end
        tick();
        total++; if (ov32 !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b want=0", ov32); end
    endtask

    task automatic test_stall();
        logic [31:0] ins = 32'hDEADBEEF;
        ir = ins[31:7];
        imm_sel = 3'd4; in_tag = 4'd5; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        ir = '1; imm_sel = 3'd7; in_tag = 4'hF;
        for (int c = 0; c < 5; c++) begin
            total++;
            if (ov32 !== 1'b1 || imm32 !== 32'hFFFDB5EA || tag32 !== 4'd5 || err32 !== 1'b0) begin
                bad++;
                $display("FAIL stall%0d got=%b/%h/%h/%b want=1/FFFDB5EA/5/0", c, ov32, imm32, tag32, err32);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        total++; if (ov32 !== 1'b0) begin bad++; $display("FAIL stall_drain got=%b want=0", ov32); end
    endtask

    task automatic test_reset_mid();
        logic seen = 1'b0;
        logic [31:0] ins = 32'h00A00093;
        ir = ins[31:7]; imm_sel = 3'd0; out_ready = 1'b0;
        in_valid = 1'b1; in_tag = 4'hA;
        tick();
        in_tag = 4'hB;
        tick();
        total++; if (rdy32 !== 1'b0) begin bad++; $display("FAIL rmid_skid got=%b want=0", rdy32); end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (ov32 !== 1'b0) begin bad++; $display("FAIL rmid_ovalid got=%b want=0", ov32); end
        total++; if (imm32 !== '0)  begin bad++; $display("FAIL rmid_imm got=%h want=0", imm32); end
        total++; if (rdy32 !== 1'b0) begin bad++; $display("FAIL rmid_inready got=%b want=0", rdy32); end
        out_ready = 1'b1;
        tick();
        total++; if (rdy32 !== 1'b1) begin bad++; $display("FAIL rmid_inready_after got=%b want=1", rdy32); end
        for (int c = 0; c < 4; c++) begin
            if (ov32 === 1'b1) seen = 1'b1;
            tick();
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL rmid_stale got=%b want=0", seen); end
    endtask

    typedef struct packed {
        logic [31:0] imm;
        logic [3:0]  tag;
        logic        err;
    } item_t;

    task automatic test_soak();
        item_t       q[$];
        item_t       exp_item;
        logic [31:0] ins;
        logic        in_fire, out_fire;
        int          errs = 0;
        int          outs = 0;
        in_valid = 1'b0; out_ready = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            if (ov32 !== (q.size() != 0)) begin
                errs++;
                if (errs <= 5) $display("FAIL soak_valid cyc=%0d got=%b want=%b", c, ov32, (q.size() != 0));
            end else if (ov32 === 1'b1) begin
                exp_item = q[0];
                if (imm32 !== exp_item.imm || tag32 !== exp_item.tag || err32 !== exp_item.err) begin
                    errs++;
                    if (errs <= 5)
                        $display("FAIL soak_data cyc=%0d got=%h/%h/%b want=%h/%h/%b", c,
                                 imm32, tag32, err32, exp_item.imm, exp_item.tag, exp_item.err);
                end
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            ins       = $urandom;
            ir        = ins[31:7];
            imm_sel   = 3'($urandom_range(0, 7));
            in_tag    = 4'($urandom_range(0, 15));
            in_fire   = in_valid && rdy32;
            out_fire  = ov32 && out_ready;
            if (out_fire) begin
                void'(q.pop_front());
                outs++;
            end
            if (in_fire) q.push_back('{imm: ref_imm32(imm_sel, ins), tag: in_tag, err: (imm_sel == 3'd7)});
            tick();
        end
        total++; if (errs != 0) begin bad++; $display("FAIL soak errors=%0d want=0", errs); end
        total++; if (outs < 1000) begin bad++; $display("FAIL soak_throughput outputs=%0d want>=1000", outs); end
    endtask

    initial begin
        test_reset();
        test_formats();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_soak();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imm_extender_pipe.md
Name: imm_extender_pipe

Overview:
- Pipelined, parametrised successor to the combinational RV32 immediate extender.
- Sits between decode and the operand mux, with a valid/ready handshake on both sides.
- Supports XLEN 32/64 and adds two formats: CSR zimm and shift amount.
- A 2-entry skid buffer gives full throughput under backpressure; an illegal-select flag and a sideband tag travel with each result.

Parameters:
- XLEN, 32, result width; legal values 32 or 64.
- TAG_W, 4, width of the sideband tag carried alongside each immediate.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- IN_VALID  in  1  upstream request valid.
- IN_READY  out  1  block can accept a request this cycle.
- IMM_SEL  in  3  format select.
- IR  in  25  instruction bits [31:7]; IR[k] = instr[k+7].
- IN_TAG  in  TAG_W  sideband tag, passed through unchanged.
- OUT_VALID  out  1  result valid.
- OUT_READY  in  1  downstream accepts the result.
- IMM  out  XLEN  extended immediate.
- OUT_TAG  out  TAG_W  tag of the current result.
- IMM_ERR  out  1  set when IMM_SEL was 111.

Behaviour:
- Format encoding (sign-extend from instr[31] to XLEN unless noted):
  - 000 I: instr[31:20].
  - 001 S: {instr[31:25], instr[11:7]}.
  - 010 B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - 011 U: {instr[31:12], 12'b0}; sign-extended above bit 31 when XLEN=64.
  - 100 J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - 101 Z: zero-extend instr[19:15].
  - 110 SHAMT: zero-extend instr[24:20] (XLEN=32) or instr[25:20] (XLEN=64).
  - 111: result computed as I-type, IMM_ERR=1.
- Transfer rules:
  - Input transfer when IN_VALID && IN_READY; output transfer when OUT_VALID && OUT_READY.
  - Latency is exactly 1 cycle: data accepted at edge N appears on IMM/OUT_TAG/IMM_ERR with OUT_VALID=1 after edge N.
  - Throughput is 1 per cycle while OUT_READY=1.
- Storage: main register (drives the outputs) plus skid register.
- States: EMPTY (main empty), FULL (main valid, skid empty), SKID (both valid).
- Transitions:
  - EMPTY + accept -> FULL.
  - FULL + accept and drain -> FULL, main reloaded with the new data.
  - FULL + accept, no drain -> SKID, new data goes to skid.
  - FULL + drain, no accept -> EMPTY.
  - SKID + drain -> FULL, skid moves to main.
- IN_READY is registered and equals !(state==SKID); it depends only on state, never combinationally on OUT_READY.
- The input side does not accept in SKID, even if OUT_READY=1 that cycle.
- Stability: while OUT_VALID=1 and OUT_READY=0, IMM, OUT_TAG and IMM_ERR hold constant.
- Ordering: strictly FIFO; the skid entry never overtakes main.
- Extension logic is evaluated at the input and stored already extended; the skid entry holds extended data.
- Reset (RST high at an edge), including mid-transfer:
  - State -> EMPTY.
  - OUT_VALID=0, IMM=0, OUT_TAG=0, IMM_ERR=0.
  - IN_READY=0 for the cycle after the reset edge, then 1 from the first cycle after RST deasserts.
  - Any in-flight or skid data is discarded.
- Inputs are ignored when IN_VALID=0; X on IR is tolerated when IN_VALID=0.

Decomposition:
- Shared package: typedef enum for IMM_SEL with names IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_Z, IMM_SH, IMM_RSVD (encodings 000-111).
- Shared package: skid state enum.
- Combinational sub-module imm_format_xlen (IMM_SEL, IR -> IMM, IMM_ERR; parameter XLEN), reused by the decoder.
- imm_extender_pipe instantiates imm_format_xlen and contains the skid/handshake logic.

Test Plan:
- Format sweep, XLEN=32, instr 0xDEADBEEF, OUT_READY=1, one request per cycle with sel 000..111. Required IMM sequence, each 1 cycle after accept:
  - I 0xFFFFFDEA, S 0xFFFFFDFD, B 0xFFFFFDFC, U 0xDEADB000, J 0xFFFDB5EA.
  - Z 0x0000001B, SHAMT 0x0000000A, 111 -> 0xFFFFFDEA with IMM_ERR=1.
  - IMM_ERR=0 for all others.
- XLEN=64, instr 0xDEADBEEF:
  - I -> 0xFFFFFFFFFFFFFDEA.
  - U -> 0xFFFFFFFFDEADB000.
  - SHAMT -> 0x000000000000002A.
- Backpressure: stream tags 1,2,3 back-to-back with OUT_READY=0.
  - Tags 1 and 2 accepted; IN_READY=0 the cycle after tag 2 is accepted.
  - Tag 3 held upstream.
  - Raise OUT_READY: outputs tags 1,2,3 in order on consecutive cycles; no loss or duplication.
- Stall stability: hold OUT_READY=0 for 5 cycles with OUT_VALID=1 -> IMM/OUT_TAG/IMM_ERR unchanged every cycle.
- Reset mid-operation: assert RST for 1 cycle while in SKID.
  - Next cycle: OUT_VALID=0, IMM=0, IN_READY=0.
  - The following cycle: IN_READY=1; none of the old tags ever appear.
- Random soak: random IN_VALID/OUT_READY for 10k cycles against a reference model queue.
  - Order is preserved; every IMM matches the format model.
